cell_exerciser: RTL and testbench
=================================

# cell_exerciser

Self-checking stimulus/response engine for the test-wafer standard cells: drives exhaustive input vectors into one selected cell instance and checks each output against a built-in truth model. Sits between the wishbone-side control registers (start, select, results) and the combinational cell array. Cells are receivers of stimulus; this block is the driver/checker end of that interface.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles a vector is held before the response is sampled (≥1).
- CNT_W, 3, settle counter width; must hold SETTLE_CYCLES.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  level; begins a run when sampled high in IDLE.
- cell_sel_i  in  5  cell index, latched at start.
- y_i  in  19  Y outputs of all cells, bit = cell index.
- stim_o  out  4  shared cell inputs: [0]=A, [1]=B, [2]=C (S for MUX2X1), [3]=D.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at end of run.
- pass_o  out  1  run completed with zero mismatches and valid select.
- fail_count_o  out  5  mismatch count (0–16).
- first_fail_o  out  4  vector index of first mismatch; 0 if none.
- sel_err_o  out  1  cell_sel ≥ 19.

## Operation
- Cell map (index: cell, inputs n, model): 0 AND2X1 2 A&B; 1 AND2X2 2 A&B; 2 AOI21X1 3 !((A&B)|C); 3 AOI22X1 4 !((A&B)|(C&D)); 4 BUFX2 1 A; 5 BUFX4 1 A; 6 CLKBUF1 1 A; 7 INV, 8 INVX1, 9 INVX2, 10 INVX4, 11 INVX8 1 !A; 12 MUX2X1 3 S?B:A; 13 NAND2X1 2 !(A&B); 14 NAND3X1 3 !(A&B&C); 15 OR2X1, 16 OR2X2 2 A|B; 17 XNOR2X1 2 !(A^B); 18 XOR2X1 2 A^B.
- Vectors k = 0 … 2^n−1 in ascending order; stim_o = k zero-extended (unused bits 0).
- FSM: IDLE → (start_i) APPLY → SETTLE → SAMPLE → APPLY (next k) or DONE → IDLE.
  - IDLE: stim_o=0, busy_o=0. On start_i: latch cell_sel, clear fail_count/first_fail/pass/sel_err.
  - Invalid select (≥19): IDLE → DONE directly; sel_err_o=1, pass_o=0, fail_count_o=0.
  - SAMPLE: compare y_i[sel] with model(k); mismatch → fail_count+1; first mismatch → first_fail_o=k.
  - DONE: done_o=1 one cycle, pass_o = (fail_count==0) & !sel_err; results held until next accepted start or reset.
- start_i ignored while busy. start_i still high in IDLE after DONE → new run.
- Reset anywhere: IDLE, all outputs 0, run aborted, results cleared.

## Timing
- All outputs registered; reset value 0 for every output.
- Start sampled at edge t → busy_o=1, stim_o=vector 0 from t+1.
- Each vector held on stim_o exactly SETTLE_CYCLES+1 cycles; y_i sampled in last cycle of window.
- Run of n inputs: busy_o high for 2^n·(SETTLE_CYCLES+1) cycles; at next cycle busy_o=0, done_o=1, stim_o=0, results valid same cycle.
- Invalid select: busy_o high 1 cycle (t+1), done_o at t+2.
- fail_count saturates impossible (max 16 fits 5 bits); no wrap.

## Test plan
- AND2X1 (sel 0), correct model, SETTLE=4 → stim_o 0,1,2,3 each 5 cycles; done_o at t+21; pass_o=1, fail_count_o=0, first_fail_o=0.
- NAND3X1 (sel 14) with y_i[14] inverted only on vector 5 → fail_count_o=1, first_fail_o=5, pass_o=0.
- AOI22X1 (sel 3) with y_i[3] stuck 0 → fail_count_o=9, first_fail_o=0, pass_o=0; busy 80 cycles.
- cell_sel=19 → done_o at t+2, sel_err_o=1, pass_o=0, stim_o stays 0.
- INVX8 (sel 11), start_i pulsed again mid-run → ignored; done after 10 busy cycles, pass_o=1; then wb_rst_i during a MUX2X1 run → next cycle all outputs 0, FSM IDLE.
- start_i held high continuously on XOR2X1 (sel 18) → back-to-back runs, done_o pulses every 22 cycles, results cleared at each restart.

Source files
------------

// File: rtl/cell_exerciser_if.sv
// rtl/cell_exerciser_if.sv - control/result and cell-array signal bundle for cell_exerciser
// Purpose: groups the register-side control/results and the cell stimulus/response lines.
// Signals:
//   start_i       level, begins a run when the exerciser is idle
//   cell_sel_i    [4:0] cell index, latched at start
//   y_i           [18:0] Y outputs of every cell, bit = cell index
//   stim_o        [3:0] shared cell inputs {D,C,B,A}
//   busy_o        run in progress
//   done_o        one-cycle end-of-run pulse
//   pass_o        run completed with zero mismatches and a valid select
//   fail_count_o  [4:0] mismatch count
//   first_fail_o  [3:0] vector index of the first mismatch
//   sel_err_o     cell select out of range
// Modports: slave = exerciser, master = controller/cell-array side.
interface cell_exerciser_if;
  logic        start_i;
  logic [4:0]  cell_sel_i;
  logic [18:0] y_i;
  logic [3:0]  stim_o;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic [4:0]  fail_count_o;
  logic [3:0]  first_fail_o;
  logic        sel_err_o;

  modport slave (
    input  start_i, cell_sel_i, y_i,
    output stim_o, busy_o, done_o, pass_o, fail_count_o, first_fail_o, sel_err_o
  );

  modport master (
    output start_i, cell_sel_i, y_i,
    input  stim_o, busy_o, done_o, pass_o, fail_count_o, first_fail_o, sel_err_o
  );
endinterface

// File: rtl/cell_exerciser.sv
// rtl/cell_exerciser.sv - exhaustive stimulus driver and truth-model checker for one test cell
// Purpose: walks every input vector of the selected cell, holds each for SETTLE_CYCLES+1
//   cycles, samples the cell's Y in the last cycle and counts mismatches against a model.
// Ports:
//   wb_clk_i  clock
//   wb_rst_i  synchronous active-high reset
//   bus       cell_exerciser_if.slave (start/select/results and stim/Y lines)
module cell_exerciser #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  cell_exerciser_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [4:0] NUM_CELLS = 5'd19;

  state_t            r_state;
  logic [4:0]        r_sel;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_stim;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [4:0]        r_fail_count;
  logic [3:0]        r_first_fail;
  logic              r_sel_err;

  logic              w_model;
  logic [3:0]        w_last_vec;
  logic              w_mismatch;
  logic [4:0]        w_fail_next;

  // Truth model; v = {D,C,B,A}, C doubles as S for the mux.
  function automatic logic cell_model(input logic [4:0] sel, input logic [3:0] v);
    logic a, b, c, d;
    a = v[0];
    b = v[1];
    c = v[2];
    d = v[3];
    case (sel)
      5'd0, 5'd1:                      cell_model = a & b;
      5'd2:                            cell_model = !((a & b) | c);
      5'd3:                            cell_model = !((a & b) | (c & d));
      5'd4, 5'd5, 5'd6:                cell_model = a;
      5'd7, 5'd8, 5'd9, 5'd10, 5'd11:  cell_model = !a;
      5'd12:                           cell_model = c ? b : a;
      5'd13:                           cell_model = !(a & b);
      5'd14:                           cell_model = !(a & b & c);
      5'd15, 5'd16:                    cell_model = a | b;
      5'd17:                           cell_model = !(a ^ b);
      5'd18:                           cell_model = a ^ b;
      default:                         cell_model = 1'b0;
    endcase
  endfunction

  // Highest vector index, i.e. 2^n - 1 for an n-input cell.
  function automatic logic [3:0] last_vec(input logic [4:0] sel);
    case (sel)
      5'd3:                                    last_vec = 4'd15;
      5'd2, 5'd12, 5'd14:                      last_vec = 4'd7;
      5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
      5'd10, 5'd11:                            last_vec = 4'd1;
      default:                                 last_vec = 4'd3;
    endcase
  endfunction

  always_comb begin
    w_model     = cell_model(r_sel, r_stim);
    w_last_vec  = last_vec(r_sel);
    w_mismatch  = (bus.y_i[r_sel] != w_model);
    w_fail_next = r_fail_count + {4'd0, w_mismatch};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_cnt        <= '0;
      r_stim       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_count <= '0;
      r_first_fail <= '0;
      r_sel_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_stim <= '0;
          if (bus.start_i) begin
            r_sel        <= bus.cell_sel_i;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b1;
            r_cnt        <= '0;
            if (bus.cell_sel_i >= NUM_CELLS) begin
              r_sel_err <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_sel_err <= 1'b0;
              r_state   <= APPLY;
            end
          end
        end
        APPLY: begin
          // APPLY and SAMPLE each take one cycle of the window; SETTLE fills the rest.
          if (SETTLE_CYCLES == 1) begin
            r_state <= SAMPLE;
          end else begin
            r_cnt   <= CNT_W'(1);
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            r_state <= SAMPLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        SAMPLE: begin
          r_fail_count <= w_fail_next;
          if (w_mismatch && (r_fail_count == 5'd0)) begin
            r_first_fail <= r_stim;
          end
          if (r_stim == w_last_vec) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_stim  <= '0;
            r_pass  <= (w_fail_next == 5'd0) && !r_sel_err;
          end else begin
            r_stim  <= r_stim + 4'd1;
            r_state <= APPLY;
          end
        end
        DONE: begin
          // Entered still busy only from an invalid select: spend one busy cycle, then pulse done.
          if (r_busy) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.stim_o       = r_stim;
  assign bus.busy_o       = r_busy;
  assign bus.done_o       = r_done;
  assign bus.pass_o       = r_pass;
  assign bus.fail_count_o = r_fail_count;
  assign bus.first_fail_o = r_first_fail;
  assign bus.sel_err_o    = r_sel_err;

endmodule

// File: tb/tb_cell_exerciser.sv
// tb/tb_cell_exerciser.sv - table-driven bench for cell_exerciser with truth-table cell array model
module tb_cell_exerciser;
  localparam int S = 4;

  logic clk;
  logic rst;
  cell_exerciser_if bus();

  cell_exerciser #(.SETTLE_CYCLES(S), .CNT_W(3)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Fault injection on the modelled cell array: 0 none, 1 invert on one vector, 2 stuck-0, 3 invert always.
  int         f_kind = 0;
  int         f_cell = 0;
  logic [3:0] f_vec  = '0;

  // Cell truth tables, bit k = output for stim value k.
  function automatic logic [15:0] tt_of(input int c);
    case (c)
      0, 1:              tt_of = 16'h8888;
      2:                 tt_of = 16'h0707;
      3:                 tt_of = 16'h0777;
      4, 5, 6:           tt_of = 16'hAAAA;
      7, 8, 9, 10, 11:   tt_of = 16'h5555;
      12:                tt_of = 16'hCACA;
      13:                tt_of = 16'h7777;
      14:                tt_of = 16'h7F7F;
      15, 16:            tt_of = 16'hEEEE;
      17:                tt_of = 16'h9999;
      18:                tt_of = 16'h6666;
      default:           tt_of = 16'h0000;
    endcase
  endfunction

  logic [18:0] w_y;
  always_comb begin
    logic [15:0] t;
    w_y = '0;
    for (int c = 0; c < 19; c++) begin
      t = tt_of(c);
      w_y[c] = t[bus.stim_o];
    end
    if (f_cell >= 0 && f_cell < 19) begin
      case (f_kind)
        1: if (bus.stim_o == f_vec) w_y[f_cell] = ~w_y[f_cell];
        2: w_y[f_cell] = 1'b0;
        3: w_y[f_cell] = ~w_y[f_cell];
        default: ;
      endcase
    end
  end
  assign bus.y_i = w_y;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] sel;
    int         fk;
    logic [3:0] fv;
    int         busy;
    int         fail;
    int         first;
    logic       pass;
    logic       serr;
  } vec_t;

  vec_t tbl [9];

  task automatic run_vec(input vec_t v);
    int cyc;
    int k;
    int bad;
    f_kind = v.fk;
    f_cell = int'(v.sel);
    f_vec  = v.fv;
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.cell_sel_i = v.sel;
    @(negedge clk);
    bus.start_i    = 1'b0;
    bus.cell_sel_i = ~v.sel;
    cyc = 0;
    bad = 0;
    while (bus.busy_o === 1'b1 && cyc < 400) begin
      k = (v.sel < 19) ? cyc / (S + 1) : 0;
      if (bus.stim_o !== 4'(k)) bad++;
      if (bus.done_o !== 1'b0) bad++;
      cyc++;
      @(negedge clk);
    end
    check($sformatf("busy_cycles sel%0d", v.sel), cyc, v.busy);
    check($sformatf("stim_seq sel%0d", v.sel), bad, 0);
    check($sformatf("done sel%0d", v.sel), bus.done_o, 1);
    check($sformatf("stim_end sel%0d", v.sel), bus.stim_o, 0);
    check($sformatf("fail_count sel%0d", v.sel), bus.fail_count_o, v.fail);
    check($sformatf("first_fail sel%0d", v.sel), bus.first_fail_o, v.first);
    check($sformatf("pass sel%0d", v.sel), bus.pass_o, v.pass);
    check($sformatf("sel_err sel%0d", v.sel), bus.sel_err_o, v.serr);
    @(negedge clk);
    check($sformatf("done_pulse sel%0d", v.sel), bus.done_o, 0);
    check($sformatf("held_fail sel%0d", v.sel), bus.fail_count_o, v.fail);
    f_kind = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    tbl[0] = '{5'd0,  0, 4'd0, 20, 0, 0, 1'b1, 1'b0};
    tbl[1] = '{5'd14, 1, 4'd5, 40, 1, 5, 1'b0, 1'b0};
    tbl[2] = '{5'd3,  2, 4'd0, 80, 9, 0, 1'b0, 1'b0};
    tbl[3] = '{5'd19, 0, 4'd0, 1,  0, 0, 1'b0, 1'b1};
    tbl[4] = '{5'd12, 0, 4'd0, 40, 0, 0, 1'b1, 1'b0};
    tbl[5] = '{5'd17, 1, 4'd3, 20, 1, 3, 1'b0, 1'b0};
    tbl[6] = '{5'd7,  2, 4'd0, 10, 1, 0, 1'b0, 1'b0};
    tbl[7] = '{5'd18, 3, 4'd0, 20, 4, 0, 1'b0, 1'b0};
    tbl[8] = '{5'd31, 0, 4'd0, 1,  0, 0, 1'b0, 1'b1};

    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.cell_sel_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.stim_o, bus.busy_o, bus.done_o, bus.pass_o,
          bus.fail_count_o, bus.first_fail_o, bus.sel_err_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // INVX8 with a second start pulse mid-run.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.cell_sel_i = 5'd11;
    @(negedge clk);
    bus.start_i = 1'b0;
    n = 0;
    while (bus.busy_o === 1'b1 && n < 100) begin
      bus.start_i = (n == 4);
      n++;
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    check("invx8_busy", n, 10);
    check("invx8_done", bus.done_o, 1);
    check("invx8_pass", bus.pass_o, 1);
    @(negedge clk);

    // Reset in the middle of a MUX2X1 run.
    bus.start_i = 1'b1;
    bus.cell_sel_i = 5'd12;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (7) @(negedge clk);
    check("mux_busy_before_rst", bus.busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_run_reset_outputs", {bus.stim_o, bus.busy_o, bus.done_o, bus.pass_o,
          bus.fail_count_o, bus.first_fail_o, bus.sel_err_o}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {bus.busy_o, bus.done_o, bus.stim_o}, 0);

    // XOR2X1 with start held high: back-to-back runs.
    f_kind = 3;
    f_cell = 18;
    bus.start_i = 1'b1;
    bus.cell_sel_i = 5'd18;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done_o !== 1'b1 && n < 100);
    check("b2b_first_done", bus.done_o, 1);
    check("b2b_first_fail_count", bus.fail_count_o, 4);
    f_kind = 0;
    n = 0;
    bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1 && bus.fail_count_o !== 5'd4) bad++;
      if (n == 2 && (bus.fail_count_o !== 5'd0 || bus.pass_o !== 1'b0 || bus.busy_o !== 1'b1)) bad++;
    end while (bus.done_o !== 1'b1 && n < 100);
    check("b2b_restart_clear", bad, 0);
    check("b2b_done_period", n, 22);
    check("b2b_second_pass", bus.pass_o, 1);
    check("b2b_second_fail_count", bus.fail_count_o, 0);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
